// File: rtl/ppu_cfg_rx.sv
// ppu_cfg_rx: captures NREG configuration bytes from an initiator, then streams them round-robin downstream.
// Optional build macro PPU_CFG_CHECKSUM_EN: a load must XOR to zero before the stream starts.
//
// state | meaning
// IDLE  | waiting for sync=1 to begin a load
// LOAD  | capturing bytes into cfg_reg[widx], one per acknowledged strobe
// FULL  | all NREG bytes held, waiting for sync=0
// RUN   | streaming cfg_reg[ridx] with valid/accept handshake
module ppu_cfg_rx #(
    parameter int NREG = 10,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync,
    input  logic [DW-1:0] data_i,
    input  logic          stb_i,
    output logic          ack_i,
    output logic [DW-1:0] data_o,
    output logic          stb_o,
    input  logic          ack_o,
    output logic          loaded,
    output logic          err
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    logic [DW-1:0] cfg_reg [NREG];

    logic capture;
    logic last_byte;
    logic load_entry;
    logic run_start;
    logic csum_ok;

    // A capture needs the previous ack to have dropped; an abort (sync low) discards it.
    assign capture    = (state == ST_LOAD) && sync && stb_i && !ack_i;
    assign last_byte  = (widx == LAST_IDX);
    assign load_entry = ((state == ST_IDLE) || (state == ST_RUN)) && sync;
    assign run_start  = (state == ST_FULL) && !sync;

`ifdef PPU_CFG_CHECKSUM_EN
    logic [DW-1:0] csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (load_entry) begin
            csum <= '0;
        end else if (capture) begin
            csum <= csum ^ data_i;
        end
    end

    assign csum_ok = (csum == '0);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sync) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!sync) begin
                    state_nxt = ST_IDLE;
                end else if (capture && last_byte) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!sync) begin
                    state_nxt = csum_ok ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sync) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stb_o  = 1'b0;
        data_o = '0;
        loaded = 1'b0;
        case (state)
            ST_FULL: begin
                loaded = 1'b1;
            end
            ST_RUN: begin
                loaded = 1'b1;
                stb_o  = 1'b1;
                data_o = cfg_reg[ridx];
            end
            default: begin
                loaded = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            widx  <= '0;
            ack_i <= 1'b0;
        end else begin
            ack_i <= capture;
            if (load_entry) begin
                widx <= '0;
            end else if (capture && !last_byte) begin
                widx <= widx + IW'(1);
            end
        end
    end

    // A pending ack_o in the cycle sync rises is ignored: ridx only moves while staying in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ridx <= '0;
        end else if (run_start) begin
            ridx <= '0;
        end else if ((state == ST_RUN) && !sync && ack_o) begin
            ridx <= (ridx == LAST_IDX) ? '0 : ridx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cfg_reg[i] <= '0;
            end
        end else if (capture) begin
            cfg_reg[widx] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (load_entry) begin
            err <= 1'b0;
        end else if ((state == ST_LOAD) && !sync) begin
            err <= 1'b1;
        end else if (run_start && !csum_ok) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_cfg_rx.sv
// Directed bench for ppu_cfg_rx: load, stream, backpressure, reload, abort and reset cases.
module tb_ppu_cfg_rx;

    logic       clk;
    logic       rst_n;
    logic       sync;
    logic [7:0] data_i;
    logic       stb_i;
    logic       ack_i;
    logic [7:0] data_o;
    logic       stb_o;
    logic       ack_o;
    logic       loaded;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] vec_a [10] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};
    logic [7:0] vec_b [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    logic [7:0] cur   [10];

    ppu_cfg_rx #(.NREG(10), .DW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync   (sync),
        .data_i (data_i),
        .stb_i  (stb_i),
        .ack_i  (ack_i),
        .data_o (data_o),
        .stb_o  (stb_o),
        .ack_o  (ack_o),
        .loaded (loaded),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has already brought the DUT into LOAD; stb_i stays high throughout.
    task automatic load_bytes(input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            stb_i  = 1'b1;
            data_i = cur[k];
            got    = 1'b0;
            for (int c = 0; c < 4 && !got; c++) begin
                step();
                if (ack_i) got = 1'b1;
            end
            chk($sformatf("ack_seen[%0d]", k), got, 1'b1);
            step();
            chk($sformatf("ack_low[%0d]", k), ack_i, 1'b0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sync   = 1'b0;
        data_i = '0;
        stb_i  = 1'b0;
        ack_o  = 1'b0;
        repeat (3) step();
        chk("rst_stb_o", stb_o, 1'b0);
        chk("rst_data_o", data_o, 8'd0);
        chk("rst_loaded", loaded, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ack_i", ack_i, 1'b0);
        rst_n = 1'b1;
        step();

        // Full load of the reference vector
        sync = 1'b1;
        step();
        chk("load_loaded_early", loaded, 1'b0);
        cur = vec_a;
        load_bytes(10);
        chk("full_loaded", loaded, 1'b1);
        chk("full_stb_o", stb_o, 1'b0);
        step();
        chk("full_ignores_stb", ack_i, 1'b0);

        // Stream with constant accept, wrapping once
        stb_i = 1'b0;
        sync  = 1'b0;
        ack_o = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            chk($sformatf("stream[%0d]", i), data_o, vec_a[i % 10]);
            chk($sformatf("stream_stb[%0d]", i), stb_o, 1'b1);
        end

        // Backpressure while 87 is presented
        ack_o = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold[%0d]", i), data_o, 8'd87);
            chk($sformatf("bp_stb[%0d]", i), stb_o, 1'b1);
        end
        ack_o = 1'b1;
        step();
        chk("bp_advance", data_o, 8'd255);
        ack_o = 1'b0;

        // Reload mid-RUN with a pending accept
        ack_o = 1'b1;
        sync  = 1'b1;
        step();
        chk("reload_stb_o", stb_o, 1'b0);
        chk("reload_data_o", data_o, 8'd0);
        chk("reload_loaded", loaded, 1'b0);
        ack_o = 1'b0;
        cur = vec_b;
        load_bytes(10);
        chk("reload_full", loaded, 1'b1);
        stb_i = 1'b0;
        sync  = 1'b0;
        ack_o = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("reload_stream[%0d]", i), data_o, vec_b[i]);
        end

        // Abort after 4 bytes; strobe is live in the abort cycle
        ack_o = 1'b0;
        sync  = 1'b1;
        step();
        cur = vec_a;
        load_bytes(4);
        data_i = 8'hE5;
        stb_i  = 1'b1;
        sync   = 1'b0;
        step();
        chk("abort_err", err, 1'b1);
        chk("abort_loaded", loaded, 1'b0);
        chk("abort_ack_i", ack_i, 1'b0);
        chk("abort_stb_o", stb_o, 1'b0);
        stb_i = 1'b0;
        repeat (2) step();
        chk("abort_err_sticky", err, 1'b1);
        sync = 1'b1;
        step();
        chk("reload_clears_err", err, 1'b0);
        sync = 1'b0;
        step();
        chk("abort_zero_bytes_err", err, 1'b1);
        rst_n = 1'b0;
        step();
        chk("rst_clears_err", err, 1'b0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of RUN
        sync = 1'b1;
        step();
        cur = vec_a;
        load_bytes(10);
        stb_i = 1'b0;
        sync  = 1'b0;
        ack_o = 1'b1;
        repeat (3) step();
        chk("pre_rst_data", data_o, vec_a[2]);
        rst_n = 1'b0;
        step();
        chk("midrun_rst_stb_o", stb_o, 1'b0);
        chk("midrun_rst_data_o", data_o, 8'd0);
        chk("midrun_rst_loaded", loaded, 1'b0);
        step();
        chk("midrun_rst_hold_stb", stb_o, 1'b0);
        rst_n = 1'b1;
        ack_o = 1'b0;
        step();

`ifdef PPU_CFG_CHECKSUM_EN
        cur = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h01};
        sync = 1'b1;
        step();
        load_bytes(10);
        stb_i = 1'b0;
        sync  = 1'b0;
        step();
        chk("csum_ok_run", stb_o, 1'b1);
        chk("csum_ok_err", err, 1'b0);
        cur[9] = 8'h02;
        sync = 1'b1;
        step();
        load_bytes(10);
        stb_i = 1'b0;
        sync  = 1'b0;
        step();
        chk("csum_bad_stb", stb_o, 1'b0);
        chk("csum_bad_err", err, 1'b1);
        chk("csum_bad_loaded", loaded, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
